// File: rtl/key_schedule_generator.sv
// DES key schedule: expands a 64-bit key into sixteen 48-bit round subkeys.
// Each subkey is then read from the internal table, one request at a time.
module key_schedule_generator (
    input  logic        clk,
    input  logic        rst,
    input  logic        key_load,
    input  logic [63:0] key,
    input  logic        subkey_req,
    input  logic [3:0]  subkey_index,
    output logic        busy,
    output logic        key_ready,
    output logic [47:0] subkey,
    output logic        subkey_valid,
    output logic        req_err
);

    typedef enum logic [1:0] {IDLE, GEN, READY} state_t;

    localparam int PC1 [56] = '{
        57, 49, 41, 33, 25, 17,  9,
         1, 58, 50, 42, 34, 26, 18,
        10,  2, 59, 51, 43, 35, 27,
        19, 11,  3, 60, 52, 44, 36,
        63, 55, 47, 39, 31, 23, 15,
         7, 62, 54, 46, 38, 30, 22,
        14,  6, 61, 53, 45, 37, 29,
        21, 13,  5, 28, 20, 12,  4
    };

    localparam int PC2 [48] = '{
        14, 17, 11, 24,  1,  5,
         3, 28, 15,  6, 21, 10,
        23, 19, 12,  4, 26,  8,
        16,  7, 27, 20, 13,  2,
        41, 52, 31, 37, 47, 55,
        30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53,
        46, 42, 50, 36, 29, 32
    };

    // Bit n in FIPS numbering sits at vector index (width - n).
    function automatic logic [55:0] f_pc1(input logic [63:0] k);
        logic [55:0] o;
        o = '0;
        for (int i = 0; i < 56; i++)
            o[6'(55 - i)] = k[6'(64 - PC1[i])];
        return o;
    endfunction

    function automatic logic [47:0] f_pc2(input logic [55:0] cd);
        logic [47:0] o;
        o = '0;
        for (int i = 0; i < 48; i++)
            o[6'(47 - i)] = cd[6'(56 - PC2[i])];
        return o;
    endfunction

    state_t      r_state;
    state_t      w_next;
    logic [27:0] r_c;
    logic [27:0] r_d;
    logic [3:0]  r_round;
    logic [47:0] r_table [16];
    logic [47:0] r_subkey;
    logic        r_valid;
    logic        r_err;

    logic        w_start;
    logic        w_ready;
    logic        w_one;
    logic [27:0] w_c_rot;
    logic [27:0] w_d_rot;
    logic [55:0] w_pc1;
    logic [47:0] w_pc2;

    always_ff @(posedge clk) begin
        if (!rst) r_state <= IDLE;
        else      r_state <= w_next;
    end

    always_comb begin
        w_next  = r_state;
        w_start = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (key_load) begin
                    w_next  = GEN;
                    w_start = 1'b1;
                end
            end
            GEN: begin
                if (r_round == 4'd15) w_next = READY;
            end
            READY: begin
                if (key_load) begin
                    w_next  = GEN;
                    w_start = 1'b1;
                end
            end
            default: w_next = IDLE;
        endcase
    end

    assign w_ready = (r_state == READY);
    assign w_one   = (r_round == 4'd0) || (r_round == 4'd1) ||
                     (r_round == 4'd8) || (r_round == 4'd15);
    assign w_c_rot = w_one ? {r_c[26:0], r_c[27]} : {r_c[25:0], r_c[27:26]};
    assign w_d_rot = w_one ? {r_d[26:0], r_d[27]} : {r_d[25:0], r_d[27:26]};
    assign w_pc1   = f_pc1(key);
    assign w_pc2   = f_pc2({w_c_rot, w_d_rot});

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_c     <= '0;
            r_d     <= '0;
            r_round <= '0;
        end else if (w_start) begin
            r_c     <= w_pc1[55:28];
            r_d     <= w_pc1[27:0];
            r_round <= '0;
        end else if (r_state == GEN) begin
            r_c     <= w_c_rot;
            r_d     <= w_d_rot;
            r_round <= r_round + 4'd1;
        end
    end

    // Table is left unreset: it can only be read once a full expansion finishes.
    always_ff @(posedge clk) begin
        if (rst && (r_state == GEN))
            r_table[r_round] <= w_pc2;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_subkey <= '0;
            r_valid  <= 1'b0;
            r_err    <= 1'b0;
        end else begin
            r_valid <= subkey_req && w_ready;
            r_err   <= subkey_req && !w_ready;
            if (subkey_req && w_ready)
                r_subkey <= r_table[subkey_index];
        end
    end

    assign busy         = (r_state == GEN);
    assign key_ready    = w_ready;
    assign subkey       = r_subkey;
    assign subkey_valid = r_valid;
    assign req_err      = r_err;

endmodule

// File: tb/tb_key_schedule_generator.sv
// Bench for key_schedule_generator: a closed-form DES key schedule model
// with a per-cycle output compare, plus directed literal vectors.
module tb_key_schedule_generator;

    localparam logic [63:0] KEY  = 64'h133457799BBCDFF1;
    localparam logic [47:0] K1   = 48'h1B02EFFC7072;
    localparam logic [47:0] K16  = 48'hCB3D8B0E17F5;

    localparam int PC1 [56] = '{
        57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
        10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
        63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
        14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4
    };
    localparam int PC2 [48] = '{
        14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
        23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
        41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
    };
    localparam int SH [16] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        key_load = 1'b0;
    logic [63:0] key = '0;
    logic        subkey_req = 1'b0;
    logic [3:0]  subkey_index = '0;
    logic        busy;
    logic        key_ready;
    logic [47:0] subkey;
    logic        subkey_valid;
    logic        req_err;

    int n_chk  = 0;
    int n_pass = 0;

    key_schedule_generator dut (
        .clk          (clk),
        .rst          (rst),
        .key_load     (key_load),
        .key          (key),
        .subkey_req   (subkey_req),
        .subkey_index (subkey_index),
        .busy         (busy),
        .key_ready    (key_ready),
        .subkey       (subkey),
        .subkey_valid (subkey_valid),
        .req_err      (req_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    // Round subkey from the total left-rotation amount, no iteration state.
    function automatic logic [47:0] ks(input logic [63:0] k, input int rnd);
        logic [28:1] c;
        logic [28:1] d;
        logic [56:1] cd;
        logic [47:0] o;
        int s;
        s = 0;
        for (int j = 0; j <= rnd; j++) s += SH[j];
        for (int n = 1; n <= 28; n++) begin
            c[5'(n)] = k[6'(64 - PC1[n - 1])];
            d[5'(n)] = k[6'(64 - PC1[n + 27])];
        end
        for (int n = 1; n <= 28; n++) begin
            cd[6'(n)]      = c[5'(((n - 1 + s) % 28) + 1)];
            cd[6'(n + 28)] = d[5'(((n - 1 + s) % 28) + 1)];
        end
        o = '0;
        for (int i = 1; i <= 48; i++) o[6'(48 - i)] = cd[6'(PC2[i - 1])];
        return o;
    endfunction

    // Reference behaviour: counts down the 16 expansion cycles.
    logic        m_on = 1'b0;
    int          m_cnt = 0;
    logic        m_ready = 1'b0;
    logic [47:0] m_tab  [16];
    logic [47:0] m_ptab [16];
    logic        e_valid = 1'b0;
    logic        e_err = 1'b0;
    logic [47:0] e_sub = '0;

    always @(posedge clk) begin
        if (!rst) begin
            m_cnt   = 0;
            m_ready = 1'b0;
            e_valid = 1'b0;
            e_err   = 1'b0;
            e_sub   = '0;
        end else begin
            e_valid = subkey_req && m_ready;
            e_err   = subkey_req && !m_ready;
            if (e_valid) e_sub = m_tab[subkey_index];
            if (m_cnt > 0) begin
                m_cnt--;
                if (m_cnt == 0) begin
                    m_ready = 1'b1;
                    m_tab   = m_ptab;
                end
            end else if (key_load) begin
                m_cnt   = 16;
                m_ready = 1'b0;
                for (int r = 0; r < 16; r++) m_ptab[r] = ks(key, r);
            end
        end
        m_on = 1'b1;
    end

    always @(negedge clk) begin
        if (m_on) begin
            chk("busy", 64'(busy), 64'(m_cnt > 0));
            chk("key_ready", 64'(key_ready), 64'(m_ready));
            chk("subkey_valid", 64'(subkey_valid), 64'(e_valid));
            chk("req_err", 64'(req_err), 64'(e_err));
            chk("subkey", 64'(subkey), 64'(e_sub));
        end
    end

    task automatic load(input logic [63:0] k);
        @(posedge clk); #1;
        key = k;
        key_load = 1'b1;
        @(posedge clk); #1;
        key_load = 1'b0;
    endtask

    task automatic wait_ready(output int lat, output int nbusy);
        int cyc;
        cyc = 0;
        nbusy = 0;
        while (!key_ready && cyc < 40) begin
            if (busy) nbusy++;
            @(posedge clk); #1;
            cyc++;
        end
        lat = cyc + 1;
    endtask

    task automatic rd(input logic [3:0] idx, output logic [47:0] v,
                      output logic vl, output logic er);
        @(posedge clk); #1;
        subkey_req = 1'b1;
        subkey_index = idx;
        @(posedge clk); #1;
        subkey_req = 1'b0;
        v = subkey;
        vl = subkey_valid;
        er = req_err;
    endtask

    initial begin
        int lat;
        int nb;
        logic [47:0] v;
        logic vl;
        logic er;

        chk("model K1", 64'(ks(KEY, 0)), 64'(K1));
        chk("model K16", 64'(ks(KEY, 15)), 64'(K16));

        repeat (2) @(posedge clk);
        #1;
        chk("reset busy", 64'(busy), 64'd0);
        chk("reset ready", 64'(key_ready), 64'd0);
        chk("reset subkey", 64'(subkey), 64'd0);
        rst = 1'b1;

        load(KEY);
        chk("gen busy", 64'(busy), 64'd1);
        rd(4'd3, v, vl, er);
        chk("gen req err", 64'(er), 64'd1);
        chk("gen req valid", 64'(vl), 64'd0);
        chk("gen req hold", 64'(v), 64'd0);
        wait_ready(lat, nb);
        chk("ready latency", 64'(lat - 2), 64'd17 - 64'd2 - 64'd2);
        chk("busy cycles", 64'(nb), 64'd14);

        rd(4'd0, v, vl, er);
        chk("K1 value", 64'(v), 64'(K1));
        chk("K1 valid", 64'(vl), 64'd1);
        #10;
        chk("valid one cycle", 64'(subkey_valid), 64'd0);
        chk("subkey hold", 64'(subkey), 64'(K1));
        rd(4'd15, v, vl, er);
        chk("K16 value", 64'(v), 64'(K16));

        for (int i = 0; i < 16; i++) begin
            @(posedge clk); #1;
            subkey_req = 1'b1;
            subkey_index = 4'(i);
            if (i > 0) begin
                chk("b2b valid", 64'(subkey_valid), 64'd1);
                chk("b2b key", 64'(subkey), 64'(ks(KEY, i - 1)));
            end
        end
        @(posedge clk); #1;
        subkey_req = 1'b0;
        chk("b2b last", 64'(subkey), 64'(K16));

        load(KEY);
        repeat (7) @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        chk("midrst busy", 64'(busy), 64'd0);
        chk("midrst ready", 64'(key_ready), 64'd0);
        chk("midrst subkey", 64'(subkey), 64'd0);
        rd(4'd0, v, vl, er);
        chk("midrst req err", 64'(er), 64'd1);
        repeat (20) @(posedge clk);
        #1;
        chk("no ready w/o load", 64'(key_ready), 64'd0);
        load(KEY);
        wait_ready(lat, nb);
        chk("reload latency", 64'(lat), 64'd17);
        rd(4'd0, v, vl, er);
        chk("reload K1", 64'(v), 64'(K1));
        rd(4'd15, v, vl, er);
        chk("reload K16", 64'(v), 64'(K16));

        load(KEY);
        repeat (3) @(posedge clk);
        #1;
        key = '0;
        key_load = 1'b1;
        @(posedge clk); #1;
        key_load = 1'b0;
        wait_ready(lat, nb);
        rd(4'd0, v, vl, er);
        chk("ignored reload K1", 64'(v), 64'(K1));

        @(posedge clk); #1;
        key = '0;
        key_load = 1'b1;
        subkey_req = 1'b1;
        subkey_index = 4'd0;
        @(posedge clk); #1;
        key_load = 1'b0;
        subkey_req = 1'b0;
        chk("same-edge K1", 64'(subkey), 64'(K1));
        chk("same-edge valid", 64'(subkey_valid), 64'd1);
        chk("same-edge ready drop", 64'(key_ready), 64'd0);
        wait_ready(lat, nb);
        chk("zero-key latency", 64'(lat), 64'd17);
        rd(4'd5, v, vl, er);
        chk("zero-key K6", 64'(v), 64'd0);

        repeat (2) @(posedge clk);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/key_schedule_generator.md
KEY_SCHEDULE_GENERATOR -- requirements
Module: key_schedule_generator

Interface
REQ-001 Parameters: none; DES geometry (16 rounds, 56-bit C/D state, 48-bit subkeys) is fixed.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset; synchronous, active-low.
REQ-004 key_load  input  1  start key expansion of `key`; sampled on the rising edge.
REQ-005 key  input  64  DES key; bit 1 (FIPS numbering) = key[63]; parity bits 8,16,...,64 are ignored.
REQ-006 subkey_req  input  1  read request for one subkey.
REQ-007 subkey_index  input  4  round index of requested subkey, 0 = K1 … 15 = K16.
REQ-008 busy  output  1  high while expansion is in progress.
REQ-009 key_ready  output  1  high while the full 16-entry subkey table is valid.
REQ-010 subkey  output  48  requested subkey; bit 1 = subkey[47].
REQ-011 subkey_valid  output  1  one-cycle strobe qualifying `subkey`.
REQ-012 req_err  output  1  one-cycle strobe flagging a request made while not ready.

Function
REQ-013 The FSM SHALL have exactly three states: IDLE, GEN, READY.
REQ-014 IDLE/READY with key_load=1 SHALL:
- load C,D <= PC-1(key);
- clear the round counter to 0;
- set busy=1 and key_ready=0;
- go to GEN.
REQ-015 Each GEN cycle at round counter r (0..15) SHALL:
- rotate C and D left by 1 for r ∈ {0,1,8,15}, else by 2;
- write PC-2 of the rotated C||D into table[r];
- increment r.
REQ-016 After the r=15 write, the FSM SHALL enter READY with busy=0 and key_ready=1, which is 17 cycles after the cycle in which key_load was sampled.
REQ-017 key_load during GEN SHALL be ignored; the expansion in progress completes unchanged.
REQ-018 key_load in READY SHALL restart expansion per REQ-014; key_ready drops on the next edge.
REQ-019 Request service in READY SHALL work as follows:
- subkey_req=1 sampled on an edge → on the following cycle subkey=table[subkey_index] and subkey_valid=1 for exactly one cycle;
- back-to-back requests are serviced every cycle.
REQ-020 subkey_req=1 while not in READY SHALL:
- pulse req_err=1 for one cycle;
- keep subkey_valid=0;
- leave subkey holding its previous value.
REQ-021 key_load and subkey_req sampled on the same edge in READY SHALL return the old table entry with subkey_valid=1, while expansion of the new key starts in parallel.
REQ-022 subkey SHALL hold its last value when subkey_valid=0.
REQ-023 table[r] SHALL be dual-use: reads in READY never collide with writes, because writes occur only in GEN.
REQ-024 subkey_index SHALL be used exactly as given, with no internal reversal; the caller selects 15-round for decryption.

Reset
REQ-025 rst=0 on a rising edge SHALL force the following, overriding all other inputs, including mid-GEN:
- state=IDLE, busy=0, key_ready=0;
- subkey_valid=0, req_err=0, subkey=0;
- C=0, D=0, round counter=0.
REQ-026 Table contents after reset are don't-care and SHALL never be observable, because reads require READY.
REQ-027 After a mid-expansion reset, a new key_load SHALL be needed before key_ready can assert.

Verification
REQ-028 Expansion vector: key=0x133457799BBCDFF1, key_load 1 cycle → key_ready high exactly 17 cycles later; busy high for those 16 GEN cycles.
REQ-029 Subkey reads after REQ-028: req index 0 → subkey=0x1B02EFFC7072; req index 15 → subkey=0xCB3D8B0E17F5; each with a single-cycle subkey_valid.
REQ-030 Back-to-back requests for indices 0..15 on consecutive cycles → 16 consecutive valid strobes, in order, matching the FIPS 46-3 K1..K16 for the REQ-028 key.
REQ-031 Request during GEN → req_err pulse, no subkey_valid; subkey unchanged.
REQ-032 Reset on the 8th GEN cycle → all outputs 0 next cycle; a request then gives req_err; reload of 0x133457799BBCDFF1 reproduces REQ-029 values.
REQ-033 Ignored reload: second key_load (key=0) during GEN is ignored → table still yields K1=0x1B02EFFC7072. Then, in READY, key_load together with req index 0 → old K1 returned with valid, followed by key_ready=0 for 17 cycles.
